uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Serial UART transmitter. Takes a parallel word with a one-cycle valid strobe and drives a framed serial line: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit.
- Each bit is held for `prescale` clk cycles, so it shares the bit-period setting used by the UART receive path.
- Sits between the system-side data source and the TX pin. It is the transmit end of the same link as the UART receiver.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (supported range 5..9).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- P_DATA  input  DATA_WIDTH  parallel word to send.
- Data_Valid  input  1  request strobe; P_DATA is valid in this cycle.
- PAR_EN  input  1  1 = parity bit inserted after data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- prescale  input  5  clk cycles per serial bit; 0 means 32.
- TX_OUT  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is on the line; registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Next cycle TX_OUT=1, busy=0, state=IDLE; bit and cycle counters = 0; holding registers = 0.
  - Reset mid-frame aborts the frame immediately. No partial stop bit is completed.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: at an edge where state=IDLE and Data_Valid=1, the block latches P_DATA, PAR_EN, PAR_TYP and prescale, and enters START.
  - Data_Valid while busy=1 is ignored. There is no queue and no error flag.
  - Input changes after accept do not affect the frame in flight.
- Parity: computed from the latched word as XOR of all bits.
  - Parity bit = XOR when PAR_TYP=0 (even).
  - Parity bit = ~XOR when PAR_TYP=1 (odd).
- Bit timing:
  - A 5-bit cycle counter runs 0..P-1, where P = latched prescale (0 wraps naturally, giving 32).
  - A state or bit advance happens at the edge where the counter reaches P-1; the counter then returns to 0.
- Transitions:
  - START: TX_OUT=0 for P cycles, then DATA with bit index 0.
  - DATA: TX_OUT=data[index] for P cycles; index increments. After index DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else to STOP.
  - PARITY: TX_OUT=parity bit for P cycles, then STOP.
  - STOP: TX_OUT=1 for P cycles, then IDLE.
- Latency: for a Data_Valid accepted at edge k:
  - TX_OUT=0 and busy=1 from cycle k+1.
  - Frame length F = (DATA_WIDTH + 2 + PAR_EN) × P cycles.
  - busy is high exactly for cycles k+1 .. k+F and returns to 0 in cycle k+F+1.
- Back-to-back: earliest next accept is at the edge ending cycle k+F+1. This gives exactly one idle-high clk cycle between frames.
- busy is purely a state indicator: busy=1 iff state≠IDLE.
- TX_OUT is glitch-free: driven from a flop, never combinational from inputs.
- Data_Valid held high continuously: a new frame starts at every opportunity, with a one-cycle gap between frames.

Test Plan:
- Reset then idle, DATA_WIDTH=8, prescale=8: hold rst 2 cycles → TX_OUT=1, busy=0. With Data_Valid=0 for 100 cycles, both stay constant.
- P_DATA=0xA5, PAR_EN=0, prescale=8: pulse Data_Valid → busy high exactly 80 cycles. Line sequence per 8-cycle slot: 0,1,0,1,0,0,1,0,1,1. The bench decodes and checks 0xA5.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0, then repeat with PAR_TYP=1, prescale=16:
  - Each frame lasts 176 cycles.
  - Parity slot = 1 for even, 0 for odd.
- Data_Valid held high with P_DATA changing every cycle, prescale=4, PAR_EN=0:
  - Each frame carries the word present at its accept edge.
  - Exactly one idle cycle between frames; frame length 40.
  - Mid-frame P_DATA and PAR_EN changes have no effect.
- prescale=0, P_DATA=0xFF, PAR_EN=0 → each bit held 32 cycles; busy high 320 cycles.
- Assert rst at cycle 30 of a prescale=8 frame (inside data bit 2) → next cycle TX_OUT=1, busy=0. A new Data_Valid 3 cycles later starts a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Each serial bit is held for a latched prescale count of clk cycles (0 means 32).
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_end_c;

  // A prescale of 0 wraps to 31 here, which gives 32-cycle bits for free.
  assign bit_end_c = (cnt_q == CNT_W'(pre_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (Data_Valid) begin
        state_q   <= START;
        cnt_q     <= '0;
        pre_q     <= prescale;
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
      end
    end else if (!bit_end_c) begin
      cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
    end else begin
      cnt_q <= '0;
      unique case (state_q)
        START: begin
          state_q <= DATA;
          idx_q   <= '0;
          tx_q    <= data_q[0];
        end
        DATA: begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_q <= par_en_q ? PARITY : STOP;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_q  <= IDX_W'(idx_q + IDX_W'(1));
            data_q <= data_q >> 1;
            tx_q   <= data_q[1];
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle queue model of the expected line plus literal frame checks.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [4:0]    prescale;
  logic          TX_OUT;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [1:0] exp_q[$];   // {tx, busy} expected for each upcoming cycle
  int         line_q[$];  // TX_OUT samples of the last captured frame

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame as a list of bit values, each stretched to P cycles.
  function automatic void push_frame(input logic [DW-1:0] d, input logic pe,
                                     input logic pt, input logic [4:0] ps);
    int p;
    int bits[$];
    p = (ps == 5'd0) ? 32 : int'(ps);
    bits.push_back(0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(int'(d[i]));
    if (pe) bits.push_back(int'((^d) ^ pt));
    bits.push_back(1);
    foreach (bits[b])
      for (int c = 0; c < p; c++) exp_q.push_back({bits[b] != 0, 1'b1});
  endfunction

  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    else if (Data_Valid) push_frame(P_DATA, PAR_EN, PAR_TYP, prescale);
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q[0] : 2'b10;
      total++;
      if ({TX_OUT, busy} !== e) begin
        bad++;
        $display("FAIL cycle_model t=%0t got tx=%b busy=%b want tx=%b busy=%b",
                 $time, TX_OUT, busy, e[1], e[0]);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Pulse Data_Valid once, then capture the line for as long as busy is high.
  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                           input logic [4:0] ps, output int len);
    @(posedge clk); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; Data_Valid = 1'b1;
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    line_q.delete();
    len = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy) break;
      line_q.push_back(int'(TX_OUT));
      len++;
    end
    if (busy) check("frame_timeout", 1, 0);
  endtask

  function automatic int slot(input int s, input int p);
    int idx;
    idx = s * p + p / 2;
    return (idx < line_q.size()) ? line_q[idx] : -1;
  endfunction

  function automatic int decode(input int p);
    int v;
    v = 0;
    for (int i = 0; i < int'(DW); i++) v |= (slot(i + 1, p) & 1) << i;
    return v;
  endfunction

  task automatic drain();
    Data_Valid = 1'b0;
    for (int n = 0; n < 2000 && busy; n++) @(negedge clk);
    if (busy) check("drain_timeout", 1, 0);
  endtask

  initial begin
    int len;
    int seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int runs[$];
    int gaps[$];
    int run_len;
    int gap_len;
    logic prev_busy;

    rst = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    prescale = 5'd8;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_tx", int'(TX_OUT), 1);
    check("reset_busy", int'(busy), 0);
    repeat (100) @(negedge clk);
    check("idle_tx", int'(TX_OUT), 1);
    check("idle_busy", int'(busy), 0);

    run_frame(8'hA5, 1'b0, 1'b0, 5'd8, len);
    check("a5_len", len, 80);
    for (int s = 0; s < 10; s++) check($sformatf("a5_slot%0d", s), slot(s, 8), seq[s]);
    check("a5_data", decode(8), 32'hA5);

    run_frame(8'h07, 1'b1, 1'b0, 5'd16, len);
    check("even_len", len, 176);
    check("even_par", slot(9, 16), 1);
    check("even_data", decode(16), 32'h07);
    run_frame(8'h07, 1'b1, 1'b1, 5'd16, len);
    check("odd_len", len, 176);
    check("odd_par", slot(9, 16), 0);
    check("odd_stop", slot(10, 16), 1);

    run_frame(8'hFF, 1'b0, 1'b0, 5'd0, len);
    check("p32_len", len, 320);
    check("p32_data", decode(32), 32'hFF);

    // Continuous Data_Valid with data changing every cycle.
    @(posedge clk); #1;
    prescale = 5'd4; PAR_EN = 1'b0; Data_Valid = 1'b1;
    prev_busy = busy; run_len = 0; gap_len = 0;
    for (int n = 0; n < 300; n++) begin
      P_DATA = DW'($urandom); PAR_TYP = 1'($urandom);
      @(negedge clk);
      if (busy) begin
        if (!prev_busy && gap_len > 0) gaps.push_back(gap_len);
        run_len++; gap_len = 0;
      end else begin
        if (prev_busy) runs.push_back(run_len);
        gap_len++; run_len = 0;
      end
      prev_busy = busy;
      @(posedge clk); #1;
    end
    check("b2b_nruns", (runs.size() >= 6) ? 1 : 0, 1);
    foreach (runs[i]) check($sformatf("b2b_len%0d", i), runs[i], 40);
    foreach (gaps[i]) check($sformatf("b2b_gap%0d", i), gaps[i], 1);
    // Same, but PAR_EN and prescale also toggle mid-frame.
    for (int n = 0; n < 300; n++) begin
      P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      prescale = 5'($urandom_range(1, 6));
      @(posedge clk); #1;
    end
    drain();

    // Reset during data bit 2 of a P=8 frame.
    @(posedge clk); #1;
    P_DATA = 8'h3C; PAR_EN = 1'b0; prescale = 5'd8; Data_Valid = 1'b1;
    @(posedge clk); #1;
    Data_Valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(TX_OUT), 1);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    run_frame(8'h5A, 1'b0, 1'b0, 5'd8, len);
    check("post_abort_len", len, 80);
    check("post_abort_data", decode(8), 32'h5A);

    // Random sparse requests, including some while busy.
    for (int n = 0; n < 1500; n++) begin
      P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      prescale = 5'($urandom_range(0, 5));
      Data_Valid = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
